crc32_frame_packer: RTL

- Sequencer and packer that sits directly around the bit-serial CRC-32 engine (poly 0x04C11DB7, 33-cycle latency after load).
- Accepts one 32-bit payload word per frame and presents it to the engine through crc_load/crc_data.
- Waits for the engine result, then emits a 2-beat frame (payload, CRC) on a valid/ready stream.
- Flags a timeout if the engine never reports a result.

---
 rtl/crc32_frame_packer_if.sv | 29 ++
 rtl/crc32_frame_packer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/crc32_frame_packer_if.sv
// Bundles the three streams around the packer: the upstream payload stream,
// the CRC engine load/result pair, and the downstream frame beat stream.
interface crc32_frame_packer_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;

  logic [31:0] crc_data;
  logic        crc_load;
  logic [31:0] crc_result;
  logic        crc_ready;

  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  // Packer side
  modport master (
    input  in_data, in_valid, crc_result, crc_ready, out_ready,
    output in_ready, crc_data, crc_load, out_data, out_valid, out_last
  );

  // Environment side: payload source, CRC engine and frame sink
  modport slave (
    output in_data, in_valid, crc_result, crc_ready, out_ready,
    input  in_ready, crc_data, crc_load, out_data, out_valid, out_last
  );
endinterface

// File: rtl/crc32_frame_packer.sv
// Sequences one payload word through the bit-serial CRC-32 engine and emits
// a two-beat (payload, CRC) frame. Every output is a register, updated from
// the next state so that it is valid in the same cycle as its state.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | in_ready high, waiting for a payload word
// LOAD      | one-cycle crc_load strobe, wait counter cleared
// WAIT      | counting engine latency; early crc_ready masked; timeout abort
// SEND_DATA | beat 0: payload, out_last low
// SEND_CRC  | beat 1: captured CRC, out_last high; frame counted on handshake
module crc32_frame_packer #(
  parameter int CRC_LAT = 33,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  crc32_frame_packer_if.master bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] LAT_M1 = WAIT_W'(CRC_LAT - 1);
  localparam logic [WAIT_W-1:0] TO_M1  = WAIT_W'(TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] TO_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT,
    S_SEND_DATA,
    S_SEND_CRC
  } state_t;

  state_t state;
  state_t next_state;

  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       payload;
  logic [31:0]       crc_reg;

  logic accept;
  logic crc_hit;
  logic timeout_hit;
  logic frame_done;

  // Event decode from the current state; a usable result beats the timeout
  always_comb begin
    accept      = (state == S_IDLE) && bus.in_valid;
    crc_hit     = (state == S_WAIT) && (wait_cnt >= LAT_M1) && bus.crc_ready;
    timeout_hit = (state == S_WAIT) && !crc_hit && (wait_cnt == TO_M1);
    frame_done  = (state == S_SEND_CRC) && bus.out_ready;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (accept) next_state = S_LOAD;
      S_LOAD:      next_state = S_WAIT;
      S_WAIT: begin
        if (crc_hit)          next_state = S_SEND_DATA;
        else if (timeout_hit) next_state = S_IDLE;
      end
      S_SEND_DATA: if (bus.out_ready) next_state = S_SEND_CRC;
      S_SEND_CRC:  if (bus.out_ready) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= next_state;
  end

  // Registered control and beat outputs, derived from the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.in_ready  <= 1'b1;
      bus.crc_load  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
      bus.out_data  <= 32'h0;
      busy          <= 1'b0;
    end else begin
      bus.in_ready  <= (next_state == S_IDLE);
      bus.crc_load  <= (next_state == S_LOAD);
      bus.out_valid <= (next_state == S_SEND_DATA) || (next_state == S_SEND_CRC);
      bus.out_last  <= (next_state == S_SEND_CRC);
      busy          <= (next_state != S_IDLE);
      case (next_state)
        S_SEND_DATA: bus.out_data <= payload;
        S_SEND_CRC:  bus.out_data <= crc_reg;
        default:     bus.out_data <= 32'h0;
      endcase
    end
  end

  // Payload and engine data capture on accept; CRC capture in the qualifying cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      payload      <= 32'h0;
      bus.crc_data <= 32'h0;
      crc_reg      <= 32'h0;
    end else begin
      if (accept) begin
        payload      <= bus.in_data;
        bus.crc_data <= bus.in_data;
      end
      if (crc_hit) crc_reg <= bus.crc_result;
    end
  end

  // Wait counter: cleared in LOAD, saturating count in WAIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (state == S_LOAD) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT && wait_cnt != TO_MAX) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Frame counter wraps; error counter saturates at all-ones
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + CNT_W'(1);
      if (timeout_hit && (err_cnt != {CNT_W{1'b1}})) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule
